// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/DM requesters, the arbiter and the single-port RAM.
interface mem_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 7
);
  // Instruction-fetch port
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_grant;
  logic                  if_done;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_stall;
  // Data-memory port
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_grant;
  logic                  dm_done;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_stall;
  // RAM side
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic                  ram_rden;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Environment side: requesters plus the RAM read-data return
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
    input  if_grant, if_done, if_rdata, if_stall,
           dm_grant, dm_done, dm_rdata, dm_stall,
           ram_addr, ram_we, ram_rden, ram_wdata
  );

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_rdata,
    output if_grant, if_done, if_rdata, if_stall,
           dm_grant, dm_done, dm_rdata, dm_stall,
           ram_addr, ram_we, ram_rden, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (IF) and
// the data-memory stage (DM): one access in flight, DM-first priority with an
// IF anti-starvation override, per-port done/rdata and stall generation.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 7,
  parameter int unsigned RAM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                state_q;
  logic                  owner_dm_q;
  logic                  we_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [STV_W-1:0]      starve_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] dm_rdata_q;

  logic idle_c;
  logic starved_c;
  logic done_c;

  // Arbitration: grants only while idle; DM first unless IF has waited too long
  assign idle_c        = rst && (state_q == IDLE);
  assign starved_c     = (starve_q == STV_W'(STARVE_LIMIT));
  assign bus.if_grant  = idle_c && bus.if_req && (!bus.dm_req || starved_c);
  assign bus.dm_grant  = idle_c && bus.dm_req && !(bus.if_req && starved_c);

  // RAM command follows the winner in the grant cycle, otherwise holds
  assign bus.ram_we    = bus.dm_grant && bus.dm_we;
  assign bus.ram_rden  = bus.if_grant || (bus.dm_grant && !bus.dm_we);
  assign bus.ram_addr  = bus.if_grant ? bus.if_addr :
                         bus.dm_grant ? bus.dm_addr : ram_addr_q;
  assign bus.ram_wdata = bus.dm_grant ? bus.dm_wdata : ram_wdata_q;

  // Completion: last BUSY cycle of the in-flight access
  assign done_c        = rst && (state_q == BUSY) && (cnt_q == '0);
  assign bus.if_done   = done_c && !owner_dm_q;
  assign bus.dm_done   = done_c && owner_dm_q;
  assign bus.if_stall  = rst && bus.if_req && !bus.if_done;
  assign bus.dm_stall  = rst && bus.dm_req && !bus.dm_done;

  // Read data passes straight through in the done cycle, then is held
  assign bus.if_rdata  = bus.if_done ? bus.ram_rdata : if_rdata_q;
  assign bus.dm_rdata  = (bus.dm_done && !we_q) ? bus.ram_rdata : dm_rdata_q;

  // FSM, latency counter, starvation counter and held read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_dm_q  <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      starve_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.if_grant || bus.dm_grant) begin
            state_q    <= BUSY;
            owner_dm_q <= bus.dm_grant;
            we_q       <= bus.ram_we;
            cnt_q      <= bus.ram_we ? '0 : CNT_W'(RAM_LATENCY - 1);
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      if (bus.if_grant || bus.dm_grant) begin
        ram_addr_q <= bus.ram_addr;
      end
      if (bus.dm_grant) begin
        ram_wdata_q <= bus.dm_wdata;
      end

      if (bus.if_grant) begin
        starve_q <= '0;
      end else if (bus.dm_grant) begin
        if (!bus.if_req) begin
          starve_q <= '0;
        end else if (!starved_c) begin
          starve_q <= starve_q + STV_W'(1);
        end
      end

      if (bus.if_done) begin
        if_rdata_q <= bus.ram_rdata;
      end
      if (bus.dm_done && !we_q) begin
        dm_rdata_q <= bus.ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural RAM, directed
// vectors, multi-cycle corner sequences and a randomized transaction model.
module tb_mem_port_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 7;
  localparam int unsigned LAT = 2;
  localparam int unsigned SL  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_LATENCY(LAT), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 5) ? 32'h0000_1234 : (32'hA5A5_0000 | 32'(i));
  endfunction

  // Behavioural RAM: reloaded while reset is held, LAT-stage read pipeline
  logic [DW-1:0] ram  [128];
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 128; i++) ram[i] <= init_word(i);
    end else if (bus.ram_we) begin
      ram[bus.ram_addr] <= bus.ram_wdata;
    end
    pipe[0] <= bus.ram_rden ? ram[bus.ram_addr] : 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.ram_rdata = pipe[LAT-1];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  function automatic logic [7:0] ctrl_bits();
    return {bus.if_grant, bus.if_done, bus.if_stall, bus.dm_grant,
            bus.dm_done, bus.dm_stall, bus.ram_we, bus.ram_rden};
  endfunction

  // One isolated transaction on one port: grant, latency, data, stall, hold
  task automatic run_txn(input bit is_dm, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, output int lat,
                         output logic [DW-1:0] rd, output logic [DW-1:0] held,
                         output bit gnt_ok, output bit stall_ok);
    bit done, stall;
    lat = -1; rd = '0; stall_ok = 1'b1;
    next();
    if (is_dm) begin
      bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    @(negedge clk);
    gnt_ok = (is_dm ? (bus.dm_grant && !bus.if_grant) : (bus.if_grant && !bus.dm_grant))
             && (bus.ram_addr == addr) && (bus.ram_we == (is_dm && we))
             && (bus.ram_rden == !(is_dm && we));
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin next(); @(negedge clk); end
      done  = is_dm ? bus.dm_done  : bus.if_done;
      stall = is_dm ? bus.dm_stall : bus.if_stall;
      if (stall == done) stall_ok = 1'b0;
      if (done) begin
        lat = c;
        rd  = is_dm ? bus.dm_rdata : bus.if_rdata;
        break;
      end
    end
    next();
    clear_inputs();
    @(negedge clk);
    held = is_dm ? bus.dm_rdata : bus.if_rdata;
  endtask

  typedef struct {
    bit            is_dm;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            exp_lat;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t tbl [7];

  // Random-phase requester state and reference model state
  bit            ireq, dreq, dwe;
  logic [AW-1:0] iaddr, daddr;
  logic [DW-1:0] dwdata;
  logic [DW-1:0] ref_mem [128];

  initial begin
    int lat;
    logic [DW-1:0] rd, held;
    bit gnt_ok, stall_ok;

    tbl[0] = '{1'b0, 1'b0, 7'h05, 32'h0,         LAT, 32'h0000_1234};
    tbl[1] = '{1'b1, 1'b1, 7'h10, 32'hDEAD_BEEF, 1,   32'h0};
    tbl[2] = '{1'b0, 1'b0, 7'h10, 32'h0,         LAT, 32'hDEAD_BEEF};
    tbl[3] = '{1'b1, 1'b0, 7'h7F, 32'h0,         LAT, 32'hA5A5_007F};
    tbl[4] = '{1'b1, 1'b1, 7'h7F, 32'h0BAD_F00D, 1,   32'hA5A5_007F};
    tbl[5] = '{1'b1, 1'b0, 7'h7F, 32'h0,         LAT, 32'h0BAD_F00D};
    tbl[6] = '{1'b0, 1'b0, 7'h00, 32'h0,         LAT, 32'hA5A5_0000};

    do_reset();
    @(negedge clk);
    chk("reset_ctrl", 32'(ctrl_bits()), 32'h0);
    chk("reset_rdata", bus.if_rdata | bus.dm_rdata | 32'(bus.ram_addr) | bus.ram_wdata, 32'h0);

    // Directed single transactions
    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].is_dm, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, rd, held, gnt_ok, stall_ok);
      chk($sformatf("vec%0d_grant", i), 32'(gnt_ok), 32'h1);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_held", i), held, tbl[i].exp_rd);
      chk($sformatf("vec%0d_stall", i), 32'(stall_ok), 32'h1);
    end

    // Simultaneous IF and DM reads: DM first, IF after DM completes
    begin
      int dg = -1, dd = -1, ig = -1, id = -1;
      bit ir = 1'b1, dr = 1'b1;
      for (int c = 0; c < 12; c++) begin
        next();
        bus.if_req = ir; bus.if_addr = 7'h01;
        bus.dm_req = dr; bus.dm_we = 1'b0; bus.dm_addr = 7'h02;
        @(negedge clk);
        if (bus.dm_grant && dg < 0) dg = c;
        if (bus.if_grant && ig < 0) ig = c;
        if (bus.dm_done && dd < 0) begin dd = c; dr = 1'b0; end
        if (bus.if_done && id < 0) begin id = c; ir = 1'b0; end
      end
      chk("both_dm_grant", 32'(dg), 32'd0);
      chk("both_dm_done",  32'(dd), 32'd2);
      chk("both_if_grant", 32'(ig), 32'd3);
      chk("both_if_done",  32'(id), 32'd5);
      chk("both_if_rdata", bus.if_rdata, 32'hA5A5_0001);
      chk("both_dm_rdata", bus.dm_rdata, 32'hA5A5_0002);
    end

    // Both requests held high: IF forced in after STARVE_LIMIT DM grants
    begin
      logic [9:0] ord = '0;
      int k = 0;
      next();
      bus.if_req = 1'b1; bus.if_addr = 7'h03;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 7'h04;
      for (int c = 0; c < 45 && k < 10; c++) begin
        if (c > 0) next();
        @(negedge clk);
        if (bus.if_grant) begin ord[k] = 1'b1; k++; end
        else if (bus.dm_grant) k++;
      end
      chk("starve_order", 32'(ord), 32'h0000_0210);
      chk("starve_grants", 32'(k), 32'd10);
    end

    // Asynchronous reset mid-cycle with requests still high
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ctrl", 32'(ctrl_bits()), 32'h0);
    chk("async_rst_addr", 32'(bus.ram_addr), 32'h0);
    chk("async_rst_wdata", bus.ram_wdata, 32'h0);
    chk("async_rst_if_rdata", bus.if_rdata, 32'h0);
    chk("async_rst_dm_rdata", bus.dm_rdata, 32'h0);
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next();
      @(negedge clk);
      chk($sformatf("post_rst_idle%0d", c), 32'(ctrl_bits()), 32'h0);
    end

    // Reset while a DM read is in flight: the access is discarded
    begin
      bit saw_done = 1'b0;
      next();
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 7'h20;
      @(negedge clk);
      chk("flight_grant", 32'(bus.dm_grant), 32'h1);
      next();
      rst = 1'b0;
      bus.dm_req = 1'b0;
      next();
      rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (bus.dm_done || bus.if_done) saw_done = 1'b1;
        next();
      end
      chk("flight_no_done", 32'(saw_done), 32'h0);
      chk("flight_dm_rdata", bus.dm_rdata, 32'h0);
      run_txn(1'b1, 1'b0, 7'h20, 32'h0, lat, rd, held, gnt_ok, stall_ok);
      chk("fresh_grant", 32'(gnt_ok), 32'h1);
      chk("fresh_latency", 32'(lat), 32'(LAT));
      chk("fresh_rdata", rd, 32'hA5A5_0020);
    end

    // Randomized traffic against a cycle-count transaction model
    do_reset();
    for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
    ireq = 1'b0; dreq = 1'b0; dwe = 1'b0; iaddr = '0; daddr = '0; dwdata = '0;
    begin
      int free_at = 0, done_at = -1, starve = 0;
      bit pend_dm = 1'b0, pend_we = 1'b0;
      logic [DW-1:0] pend_rd = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        bit eig, edg, eid, edd;
        next();
        if (!ireq && $urandom_range(0, 2) == 0) begin
          ireq = 1'b1; iaddr = AW'($urandom_range(0, 127));
        end
        if (!dreq && $urandom_range(0, 3) != 0) begin
          dreq = 1'b1; dwe = 1'($urandom_range(0, 1));
          daddr = AW'($urandom_range(0, 15)); dwdata = $urandom;
        end
        bus.if_req = ireq; bus.if_addr = iaddr;
        bus.dm_req = dreq; bus.dm_we = dwe; bus.dm_addr = daddr; bus.dm_wdata = dwdata;
        @(negedge clk);

        eig = 1'b0; edg = 1'b0;
        if (cyc >= free_at && (ireq || dreq)) begin
          int l;
          if (ireq && (!dreq || starve == SL)) begin
            eig = 1'b1; starve = 0;
            pend_dm = 1'b0; pend_we = 1'b0; pend_rd = ref_mem[iaddr]; l = LAT;
          end else begin
            edg = 1'b1;
            starve = ireq ? ((starve < SL) ? starve + 1 : SL) : 0;
            pend_dm = 1'b1; pend_we = dwe; pend_rd = ref_mem[daddr];
            if (dwe) ref_mem[daddr] = dwdata;
            l = dwe ? 1 : LAT;
          end
          done_at = cyc + l;
          free_at = done_at + 1;
        end
        eid = (cyc == done_at) && !pend_dm;
        edd = (cyc == done_at) && pend_dm;

        chk($sformatf("rnd%0d_handshake", cyc),
            32'({bus.if_grant, bus.dm_grant, bus.if_done, bus.dm_done, bus.if_stall, bus.dm_stall}),
            32'({eig, edg, eid, edd, ireq && !eid, dreq && !edd}));
        if (eig || edg)
          chk($sformatf("rnd%0d_ram_cmd", cyc),
              32'({bus.ram_addr, bus.ram_we, bus.ram_rden}),
              32'({eig ? iaddr : daddr, edg && dwe, eig || !dwe}));
        if (eid) chk($sformatf("rnd%0d_if_rdata", cyc), bus.if_rdata, pend_rd);
        if (edd && !pend_we) chk($sformatf("rnd%0d_dm_rdata", cyc), bus.dm_rdata, pend_rd);
        if (eid) ireq = 1'b0;
        if (edd) dreq = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
